oam_dma: RTL and testbench

- Bus-master copy engine feeding sprite attribute memory (OAM, 0xFE00-0xFE9F) in the graphics peripheral.
- A CPU write of page byte N to the DMA register copies 160 bytes from N*0x100 into OAM, one read/write pair per byte, over the shared data bus.
- Drives dma_active so the bus arbiter locks the CPU out of non-HRAM space during the transfer.

---
 rtl/oam_dma_pkg.sv | 25 ++
 rtl/oam_dma.sv | 158 +++++++++++++++
 tb/tb_oam_dma.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_pkg.sv
// Shared video-block definitions used by the OAM DMA engine.
//   DMA_REG_ADDR : CPU address of the DMA page register (decoded upstream)
//   OAM_LOC      : base address of sprite attribute memory
//   OAM_SIZE     : bytes in the sprite attribute table
//   DmaState     : DMA engine state encoding (also exported for debug)
//   echo_remap   : folds echo-RAM pages (0xE0-0xFF) onto work RAM
package oam_dma_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_LOC      = 16'hFE00;
  localparam int          OAM_SIZE     = 160;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_DELAY,
    DMA_RD,
    DMA_WR
  } DmaState;

  // Pages 0xE0-0xFF mirror 0xC0-0xDF, so the engine reads the real RAM.
  function automatic logic [7:0] echo_remap(input logic [7:0] page);
    return (page >= 8'hE0) ? (page - 8'h20) : page;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a write of page byte N copies OAM_BYTES bytes from
// N*0x100 into OAM_BASE.., one bus read then one bus write per byte.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   reg_wr_en, reg_wdata  DMA register write strobe and page byte
//   reg_rdata             last value written to the DMA register
//   mst_req/we/addr/wdata bus master request (held until mst_ack)
//   mst_ack, mst_rdata    bus completion and read data
//   dma_active            transfer in progress (bus arbiter lockout)
//   dma_done              one-cycle pulse after the last OAM write
//   dbg_state             current engine state
//
// Bus handshake: a request is presented by holding mst_req high with
// mst_we/mst_addr/mst_wdata stable; it completes in the cycle mst_ack is
// sampled high. mst_ack with mst_req low is ignored; waits are unbounded.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] OAM_BASE    = OAM_LOC,
  parameter int          OAM_BYTES   = OAM_SIZE,
  parameter int          START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_wr_en,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        mst_req,
  output logic        mst_we,
  output logic [15:0] mst_addr,
  output logic [7:0]  mst_wdata,
  input  logic        mst_ack,
  input  logic [7:0]  mst_rdata,
  output logic        dma_active,
  output logic        dma_done,
  output DmaState     dbg_state
);

  localparam logic [7:0] LAST_IDX   = 8'(OAM_BYTES - 1);
  localparam logic [7:0] DELAY_INIT = 8'(START_DELAY);
  // With no start delay a (re)start goes straight to the first read.
  localparam DmaState    START_STATE = (START_DELAY == 0) ? DMA_RD : DMA_DELAY;

  DmaState    state, state_nxt;
  logic [7:0] src_page;   // remapped page from the most recent register write
  logic [7:0] cur_page;   // page used by the running transfer
  logic [7:0] index;
  logic [7:0] delay_cnt;
  logic [7:0] byte_buf;
  logic       pending;    // restart requested while a bus transaction was open

  logic       restart, idx_inc, cnt_dec, latch, done_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= DMA_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    idx_inc   = 1'b0;
    cnt_dec   = 1'b0;
    latch     = 1'b0;
    done_set  = 1'b0;
    mst_req   = 1'b0;
    mst_we    = 1'b0;
    mst_addr  = 16'h0000;
    mst_wdata = 8'h00;
    unique case (state)
      DMA_IDLE: begin
        if (reg_wr_en) begin
          restart   = 1'b1;
          state_nxt = START_STATE;
        end
      end
      DMA_DELAY: begin
        // No transaction open here, so a new write restarts at once.
        if (reg_wr_en) begin
          restart   = 1'b1;
          state_nxt = START_STATE;
        end else if (delay_cnt <= 8'd1) begin
          state_nxt = DMA_RD;           // count reaches zero this cycle
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DMA_RD: begin
        mst_req  = 1'b1;
        mst_addr = {cur_page, index};
        if (mst_ack) begin
          if (pending || reg_wr_en) begin
            restart   = 1'b1;
            state_nxt = START_STATE;
          end else begin
            latch     = 1'b1;
            state_nxt = DMA_WR;
          end
        end
      end
      DMA_WR: begin
        mst_req   = 1'b1;
        mst_we    = 1'b1;
        mst_addr  = OAM_BASE + {8'h00, index};
        mst_wdata = byte_buf;
        if (mst_ack) begin
          // A restart wins over completion: no done pulse, stays active.
          if (pending || reg_wr_en) begin
            restart   = 1'b1;
            state_nxt = START_STATE;
          end else if (index == LAST_IDX) begin
            done_set  = 1'b1;
            state_nxt = DMA_IDLE;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = DMA_RD;
          end
        end
      end
      default: state_nxt = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_rdata <= 8'h00;
      src_page  <= 8'h00;
      cur_page  <= 8'h00;
      index     <= 8'h00;
      delay_cnt <= 8'h00;
      byte_buf  <= 8'h00;
      pending   <= 1'b0;
      dma_done  <= 1'b0;
    end else begin
      dma_done <= done_set;
      if (reg_wr_en) begin
        reg_rdata <= reg_wdata;
        src_page  <= echo_remap(reg_wdata);
      end
      if (restart) begin
        index     <= 8'h00;
        delay_cnt <= DELAY_INIT;
        pending   <= 1'b0;
        // The page changes only at a (re)start so an open read keeps its address.
        cur_page  <= reg_wr_en ? echo_remap(reg_wdata) : src_page;
      end else begin
        if (reg_wr_en && (state != DMA_IDLE)) pending <= 1'b1;
        if (idx_inc) index     <= index + 8'd1;
        if (cnt_dec) delay_cnt <= delay_cnt - 8'd1;
      end
      if (latch) byte_buf <= mst_rdata;
    end
  end

  assign dma_active = (state != DMA_IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a bus responder with a memory model,
// per-scenario test tasks and a reference model of the copy.
module tb_oam_dma;
  import oam_dma_pkg::*;

  localparam int START_DELAY = 1;
  localparam int OAM_BYTES   = 160;
  localparam int DONE_CYCLE  = 1 + START_DELAY + 2 * OAM_BYTES;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reg_wr_en = 1'b0;
  logic [7:0]  reg_wdata = 8'h00;
  logic [7:0]  reg_rdata;
  logic        mst_req, mst_we;
  logic [15:0] mst_addr;
  logic [7:0]  mst_wdata;
  logic        mst_ack = 1'b0;
  logic [7:0]  mst_rdata = 8'h00;
  logic        dma_active, dma_done;
  DmaState     dbg_state;

  oam_dma #(.OAM_BASE(16'hFE00), .OAM_BYTES(OAM_BYTES), .START_DELAY(START_DELAY)) dut (
    .clk(clk), .reset_n(reset_n), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .mst_req(mst_req), .mst_we(mst_we), .mst_addr(mst_addr),
    .mst_wdata(mst_wdata), .mst_ack(mst_ack), .mst_rdata(mst_rdata),
    .dma_active(dma_active), .dma_done(dma_done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  mem [65536];
  logic [7:0]  oam_got [160];
  int          n_oob = 0;
  logic [15:0] rd_log [$];
  logic [15:0] exp_q  [$];

  // responder controls
  int          max_wait = 0;
  bit          noise_en = 1'b0;
  bit          check_stable = 1'b0;
  logic [15:0] stall_addr = 16'hFFFF;

  // ---------------- bus responder ----------------
  bit          in_txn = 1'b0;
  int          wait_left = 0;
  logic [15:0] cap_addr;
  logic        cap_we;
  logic [7:0]  cap_wdata;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_txn  = 1'b0;
        mst_ack = 1'b0;
      end else if (mst_req) begin
        if (!in_txn) begin
          in_txn    = 1'b1;
          cap_addr  = mst_addr;
          cap_we    = mst_we;
          cap_wdata = mst_wdata;
          wait_left = (!mst_we && mst_addr == stall_addr) ? 6 : int'($urandom_range(0, max_wait));
        end else if (check_stable) begin
          n_cmp++;
          if (mst_addr !== cap_addr || mst_we !== cap_we || (mst_we && mst_wdata !== cap_wdata)) begin
            n_err++;
            $display("FAIL stable_req: got addr=%h we=%b wdata=%h, held addr=%h we=%b wdata=%h",
                     mst_addr, mst_we, mst_wdata, cap_addr, cap_we, cap_wdata);
          end
        end
        if (wait_left > 0) begin
          wait_left--;
          mst_ack = 1'b0;
        end else begin
          mst_ack = 1'b1;
          in_txn  = 1'b0;
          if (mst_we) begin
            if (mst_addr >= 16'hFE00 && mst_addr < 16'hFEA0) oam_got[mst_addr - 16'hFE00] = mst_wdata;
            else n_oob++;
          end else begin
            mst_rdata = mem[mst_addr];
            rd_log.push_back(mst_addr);
          end
        end
      end else begin
        in_txn    = 1'b0;
        mst_ack   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        mst_rdata = 8'($urandom);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] page_of(input logic [7:0] w);
    return (w >= 8'hE0) ? (w - 8'h20) : w;
  endfunction

  task automatic model_reads(input logic [7:0] w);
    for (int i = 0; i < OAM_BYTES; i++) exp_q.push_back({page_of(w), 8'(i)});
  endtask

  function automatic logic [7:0] exp_oam(input logic [7:0] w, input int i);
    return mem[{page_of(w), 8'(i)}];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic fill_page(input logic [7:0] page);
    for (int i = 0; i < 256; i++) mem[{page, 8'(i)}] = 8'($urandom);
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 160; i++) oam_got[i] = 8'hxx;
    rd_log.delete();
    exp_q.delete();
    n_oob = 0;
  endtask

  // Drives the register write in the current cycle; returns at the next negedge (cycle 1).
  task automatic pulse_write_now(input logic [7:0] page);
    reg_wr_en = 1'b1;
    reg_wdata = page;
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] page);
    @(negedge clk);
    pulse_write_now(page);
  endtask

  task automatic wait_for_req(input logic [15:0] addr, input logic we, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (mst_req && mst_we == we && mst_addr == addr) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Samples from the current negedge (cycle 1 after a trigger) until a done pulse plus a few cycles.
  task automatic run_until_done(input int budget, output int done_cyc, output int n_done,
                                output int n_active, output int last_active);
    bit seen = 1'b0;
    int extra = 0;
    done_cyc = -1; n_done = 0; n_active = 0; last_active = -1;
    for (int k = 1; k <= budget; k++) begin
      if (dma_active) begin n_active++; last_active = k; end
      if (dma_done) begin
        n_done++;
        if (!seen) done_cyc = k;
        seen = 1'b1;
      end else if (seen) extra++;
      @(negedge clk);
      if (seen && extra >= 4) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (mst_req !== 1'b0)    begin n_err++; $display("FAIL reset_req: got %b want 0", mst_req); end
    n_cmp++; if (mst_we !== 1'b0)     begin n_err++; $display("FAIL reset_we: got %b want 0", mst_we); end
    n_cmp++; if (mst_addr !== 16'h0)  begin n_err++; $display("FAIL reset_addr: got %h want 0000", mst_addr); end
    n_cmp++; if (mst_wdata !== 8'h0)  begin n_err++; $display("FAIL reset_wdata: got %h want 00", mst_wdata); end
    n_cmp++; if (reg_rdata !== 8'h0)  begin n_err++; $display("FAIL reset_rdata: got %h want 00", reg_rdata); end
    n_cmp++; if (dma_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", dma_active); end
    n_cmp++; if (dma_done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b want 0", dma_done); end
    n_cmp++; if (dbg_state !== DMA_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    int dc, nd, na, la, bad;
    for (int i = 0; i < 256; i++) mem[{8'hC0, 8'(i)}] = 8'(i) ^ 8'h5A;
    clear_obs();
    model_reads(8'hC0);
    max_wait = 0;
    do_write(8'hC0);
    run_until_done(400, dc, nd, na, la);
    n_cmp++; if (dc != DONE_CYCLE) begin n_err++; $display("FAIL zw_done_cycle: got %0d want %0d", dc, DONE_CYCLE); end
    n_cmp++; if (nd != 1)          begin n_err++; $display("FAIL zw_done_count: got %0d want 1", nd); end
    n_cmp++; if (na != DONE_CYCLE - 1 || la != DONE_CYCLE - 1)
      begin n_err++; $display("FAIL zw_active_span: got %0d cycles last %0d want %0d", na, la, DONE_CYCLE - 1); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= rd_log.size() || rd_log[i] !== exp_q[i])) bad = i;
    n_cmp++; if (bad >= 0 || rd_log.size() != exp_q.size())
      begin n_err++; $display("FAIL zw_reads: first bad index %0d, got %0d reads want %0d", bad, rd_log.size(), exp_q.size()); end
    for (int i = 0; i < OAM_BYTES; i++) begin
      n_cmp++;
      if (oam_got[i] !== (8'(i) ^ 8'h5A)) begin n_err++; $display("FAIL zw_oam[%0d]: got %h want %h", i, oam_got[i], 8'(i) ^ 8'h5A); end
    end
    n_cmp++; if (n_oob != 0) begin n_err++; $display("FAIL zw_oob_writes: got %0d want 0", n_oob); end
  endtask

  task automatic test_wait_states();
    int dc, nd, na, la;
    fill_page(8'hC0);
    clear_obs();
    max_wait = 3; noise_en = 1'b1; check_stable = 1'b1;
    do_write(8'hC0);
    run_until_done(2000, dc, nd, na, la);
    max_wait = 0; noise_en = 1'b0; check_stable = 1'b0;
    n_cmp++; if (nd != 1) begin n_err++; $display("FAIL ws_done_count: got %0d want 1", nd); end
    for (int i = 0; i < OAM_BYTES; i++) begin
      n_cmp++;
      if (oam_got[i] !== exp_oam(8'hC0, i)) begin n_err++; $display("FAIL ws_oam[%0d]: got %h want %h", i, oam_got[i], exp_oam(8'hC0, i)); end
    end
    n_cmp++; if (n_oob != 0) begin n_err++; $display("FAIL ws_oob_writes: got %0d want 0", n_oob); end
  endtask

  task automatic test_restart();
    int dc, nd, na, la, bad;
    bit ok;
    fill_page(8'hC0);
    fill_page(8'hD0);
    clear_obs();
    for (int i = 0; i <= 50; i++) exp_q.push_back(16'hC000 + 16'(i));
    model_reads(8'hD0);
    stall_addr = 16'hC032;
    do_write(8'hC0);
    wait_for_req(16'hC032, 1'b0, 400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rs_reach_byte50: got timeout want read at C032"); end
    pulse_write_now(8'hD0);
    n_cmp++; if (reg_rdata !== 8'hD0) begin n_err++; $display("FAIL rs_rdata: got %h want D0", reg_rdata); end
    n_cmp++; if (mst_req !== 1'b1 || mst_we !== 1'b0 || mst_addr !== 16'hC032)
      begin n_err++; $display("FAIL rs_inflight: got req=%b we=%b addr=%h want 1 0 C032", mst_req, mst_we, mst_addr); end
    n_cmp++; if (dma_active !== 1'b1) begin n_err++; $display("FAIL rs_active: got %b want 1", dma_active); end
    run_until_done(1000, dc, nd, na, la);
    stall_addr = 16'hFFFF;
    n_cmp++; if (nd != 1) begin n_err++; $display("FAIL rs_done_count: got %0d want 1", nd); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= rd_log.size() || rd_log[i] !== exp_q[i])) bad = i;
    n_cmp++; if (bad >= 0 || rd_log.size() != exp_q.size())
      begin n_err++; $display("FAIL rs_reads: first bad index %0d, got %0d reads want %0d", bad, rd_log.size(), exp_q.size()); end
    for (int i = 0; i < OAM_BYTES; i++) begin
      n_cmp++;
      if (oam_got[i] !== exp_oam(8'hD0, i)) begin n_err++; $display("FAIL rs_oam[%0d]: got %h want %h", i, oam_got[i], exp_oam(8'hD0, i)); end
    end
  endtask

  task automatic test_echo();
    int dc, nd, na, la, bad;
    fill_page(8'hE1);
    fill_page(8'hF1);
    clear_obs();
    model_reads(8'hF1);
    do_write(8'hF1);
    n_cmp++; if (reg_rdata !== 8'hF1) begin n_err++; $display("FAIL echo_rdata: got %h want F1", reg_rdata); end
    run_until_done(400, dc, nd, na, la);
    n_cmp++; if (nd != 1) begin n_err++; $display("FAIL echo_done_count: got %0d want 1", nd); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= rd_log.size() || rd_log[i] !== exp_q[i])) bad = i;
    n_cmp++; if (bad >= 0 || rd_log.size() != exp_q.size())
      begin n_err++; $display("FAIL echo_reads: first bad index %0d, got %0d reads want %0d", bad, rd_log.size(), exp_q.size()); end
    for (int i = 0; i < OAM_BYTES; i++) begin
      n_cmp++;
      if (oam_got[i] !== exp_oam(8'hF1, i)) begin n_err++; $display("FAIL echo_oam[%0d]: got %h want %h", i, oam_got[i], exp_oam(8'hF1, i)); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int busy;
    fill_page(8'hC0);
    clear_obs();
    do_write(8'hC0);
    wait_for_req(16'hC050, 1'b0, 400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rm_reach_byte80: got timeout want read at C050"); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (mst_req !== 1'b0)    begin n_err++; $display("FAIL rm_req: got %b want 0", mst_req); end
    n_cmp++; if (dma_active !== 1'b0) begin n_err++; $display("FAIL rm_active: got %b want 0", dma_active); end
    n_cmp++; if (reg_rdata !== 8'h00) begin n_err++; $display("FAIL rm_rdata: got %h want 00", reg_rdata); end
    @(negedge clk);
    reset_n = 1'b1;
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (mst_req || dma_active || dma_done) busy++;
    end
    n_cmp++; if (busy != 0) begin n_err++; $display("FAIL rm_quiet_after: got %0d busy cycles want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int dc, nd, na, la, bad;
    bit ok;
    logic [7:0] p1, p2;
    p1 = 8'($urandom_range(8'h80, 8'hDF));
    p2 = 8'($urandom_range(8'h00, 8'h7F));
    fill_page(p1);
    fill_page(p2);
    clear_obs();
    do_write(p1);
    wait_for_req(16'hFE9F, 1'b1, 400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_reach_last: got timeout want write at FE9F"); end
    clear_obs();
    model_reads(p2);
    pulse_write_now(p2);
    n_cmp++; if (dma_done !== 1'b0)   begin n_err++; $display("FAIL b2b_no_done: got %b want 0", dma_done); end
    n_cmp++; if (dma_active !== 1'b1) begin n_err++; $display("FAIL b2b_active: got %b want 1", dma_active); end
    n_cmp++; if (mst_req !== 1'b0 || dbg_state !== DMA_DELAY)
      begin n_err++; $display("FAIL b2b_delay: got req=%b state=%0d want 0 DELAY", mst_req, dbg_state); end
    @(negedge clk);
    n_cmp++; if (mst_req !== 1'b1 || mst_we !== 1'b0 || mst_addr !== {p2, 8'h00})
      begin n_err++; $display("FAIL b2b_first_read: got req=%b we=%b addr=%h want 1 0 %h", mst_req, mst_we, mst_addr, {p2, 8'h00}); end
    run_until_done(400, dc, nd, na, la);
    n_cmp++; if (nd != 1) begin n_err++; $display("FAIL b2b_done_count: got %0d want 1", nd); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= rd_log.size() || rd_log[i] !== exp_q[i])) bad = i;
    n_cmp++; if (bad >= 0 || rd_log.size() != exp_q.size())
      begin n_err++; $display("FAIL b2b_reads: first bad index %0d, got %0d reads want %0d", bad, rd_log.size(), exp_q.size()); end
    for (int i = 0; i < OAM_BYTES; i++) begin
      n_cmp++;
      if (oam_got[i] !== exp_oam(p2, i)) begin n_err++; $display("FAIL b2b_oam[%0d]: got %h want %h", i, oam_got[i], exp_oam(p2, i)); end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_restart();
    test_echo();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
